// File: rtl/nhancong_nbit_seq.sv
// Sequential multiply-add P = A*B + C*C, optionally accumulated into P with saturation.
// Latency: 2N cycles from the accepting edge to done; one operation per 2N+1 cycles.
// Backpressure: start is only sampled while busy is low; it is never queued.
module nhancong_nbit_seq #(
  parameter int N  = 3,
  parameter int AW = 2*N+4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          acc_mode,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [N-1:0]  C,
  output logic [AW-1:0] P,
  output logic          done,
  output logic          busy,
  output logic          ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL_AB = 2'd1,
    MUL_CC = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [N-1:0]   op_c;
  logic [CW-1:0]  cnt;
  logic [AW-1:0]  acc;
  logic           op_ovf;

  logic [AW:0]    addend;
  logic [AW:0]    sum;
  logic           add_en;
  logic [AW-1:0]  acc_nxt;
  logic           ovf_nxt;

  // One partial product per cycle; the sum is one bit wider so a carry out means saturate.
  always_comb begin
    addend  = '0;
    add_en  = 1'b0;
    if (state == MUL_AB) begin
      add_en = op_b[cnt];
      addend = {{(AW+1-N){1'b0}}, op_a} << cnt;
    end else if (state == MUL_CC) begin
      add_en = op_c[cnt];
      addend = {{(AW+1-N){1'b0}}, op_c} << cnt;
    end
    sum = {1'b0, acc} + (add_en ? addend : {(AW+1){1'b0}});
    if (sum[AW]) begin
      acc_nxt = '1;
      ovf_nxt = 1'b1;
    end else begin
      acc_nxt = sum[AW-1:0];
      ovf_nxt = op_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      op_c   <= '0;
      cnt    <= '0;
      acc    <= '0;
      op_ovf <= 1'b0;
      P      <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= A;
            op_b   <= B;
            op_c   <= C;
            acc    <= acc_mode ? P : '0;
            op_ovf <= acc_mode ? ovf : 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= MUL_AB;
          end
        end
        MUL_AB: begin
          acc    <= acc_nxt;
          op_ovf <= ovf_nxt;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= MUL_CC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MUL_CC: begin
          acc    <= acc_nxt;
          op_ovf <= ovf_nxt;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            P     <= acc_nxt;
            ovf   <= ovf_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nhancong_nbit_seq.sv
// Randomized and directed bench for nhancong_nbit_seq against an arithmetic reference model.
module tb_nhancong_nbit_seq;

  localparam int N   = 3;
  localparam int AW  = 10;
  localparam int MAXP = (1 << AW) - 1;
  localparam int N8  = 8;
  localparam int AW8 = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, acc_mode;
  logic [N-1:0]  A, B, C;
  logic [AW-1:0] P;
  logic          done, busy, ovf;

  logic           start8, acc_mode8;
  logic [N8-1:0]  a8, b8, c8;
  logic [AW8-1:0] p8;
  logic           done8, busy8, ovf8;

  int n_vec = 0;
  int n_err = 0;
  int mdl_p = 0;
  bit mdl_o = 1'b0;

  always #5 clk = ~clk;

  nhancong_nbit_seq #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode),
    .A(A), .B(B), .C(C), .P(P), .done(done), .busy(busy), .ovf(ovf)
  );

  nhancong_nbit_seq #(.N(N8), .AW(AW8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .acc_mode(acc_mode8),
    .A(a8), .B(b8), .C(c8), .P(p8), .done(done8), .busy(busy8), .ovf(ovf8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: the whole operation as one sum, clamped; sticky ovf in accumulate mode.
  task automatic run_op(input int a, input int b, input int c, input bit m, input string tag);
    int exp_p;
    bit exp_o;
    int lat;
    if (m) begin
      exp_p = mdl_p + a*b + c*c;
      exp_o = mdl_o;
      if (exp_p > MAXP) begin
        exp_p = MAXP;
        exp_o = 1'b1;
      end
    end else begin
      exp_p = a*b + c*c;
      exp_o = 1'b0;
    end
    @(negedge clk);
    start = 1'b1; acc_mode = m; A = N'(a); B = N'(b); C = N'(c);
    @(posedge clk); #1;
    start = 1'b0;
    A = '1; B = '1; C = '1; acc_mode = ~m;
    check({tag, ".busy"}, 32'(busy), 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) check({tag, ".P_hold"}, 32'(P), mdl_p);
    end
    check({tag, ".latency"}, lat, 2*N);
    check({tag, ".P"}, 32'(P), exp_p);
    check({tag, ".ovf"}, 32'(ovf), 32'(exp_o));
    check({tag, ".busy_done"}, 32'(busy), 0);
    mdl_p = exp_p;
    mdl_o = exp_o;
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 0);
  endtask

  task automatic run8(input int a, input int b, input int c, input string tag);
    int lat;
    @(negedge clk);
    start8 = 1'b1; acc_mode8 = 1'b0; a8 = N8'(a); b8 = N8'(b); c8 = N8'(c);
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 2*N8);
    check({tag, ".P"}, 32'(p8), a*b + c*c);
    check({tag, ".ovf"}, 32'(ovf8), 0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, ".drain"}, 32'(busy), 0);
  endtask

  initial begin
    int nd, last, a, b, c;
    bit m;
    rst_n = 1'b0; start = 1'b0; acc_mode = 1'b0; A = '0; B = '0; C = '0;
    start8 = 1'b0; acc_mode8 = 1'b0; a8 = '0; b8 = '0; c8 = '0;
    repeat (2) @(negedge clk);
    check("rst.P", 32'(P), 0);
    check("rst.done", 32'(done), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.ovf", 32'(ovf), 0);
    rst_n = 1'b1;

    // Plain multiply-add
    run_op(7, 2, 4, 0, "tp1"); check("tp1.const", 32'(P), 30);
    run_op(4, 6, 2, 0, "tp2"); check("tp2.const", 32'(P), 28);
    run_op(0, 7, 3, 0, "tp3"); check("tp3.const", 32'(P), 9);
    run_op(4, 2, 0, 0, "tp4"); check("tp4.const", 32'(P), 8);

    // Accumulate
    run_op(7, 2, 4, 0, "acc0");
    run_op(4, 6, 2, 1, "acc1"); check("acc1.const", 32'(P), 58);
    run_op(6, 5, 1, 1, "acc2"); check("acc2.const", 32'(P), 89);

    // Saturation
    run_op(7, 7, 7, 0, "sat0"); check("sat0.const", 32'(P), 98);
    for (int i = 1; i <= 10; i++) begin
      run_op(7, 7, 7, 1, "sat");
      if (i == 9) begin
        check("sat9.P", 32'(P), 980);
        check("sat9.ovf", 32'(ovf), 0);
      end
    end
    check("sat10.P", 32'(P), 1023);
    check("sat10.ovf", 32'(ovf), 1);
    run_op(7, 7, 7, 1, "sat11");
    check("sat11.P", 32'(P), 1023);
    check("sat11.ovf", 32'(ovf), 1);
    run_op(1, 1, 0, 0, "satclr");
    check("satclr.P", 32'(P), 1);
    check("satclr.ovf", 32'(ovf), 0);

    // start pulsed while busy is ignored
    @(negedge clk);
    start = 1'b1; acc_mode = 1'b0; A = 3'd7; B = 3'd2; C = 3'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    start = 1'b1; acc_mode = 1'b1; A = 3'd1; B = 3'd1; C = 3'd1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        check("ign.P", 32'(P), 30);
        check("ign.ovf", 32'(ovf), 0);
      end
    end
    check("ign.done_count", nd, 1);
    mdl_p = 30; mdl_o = 1'b0;

    // start held high: back-to-back every 2N+1 cycles
    @(negedge clk);
    start = 1'b1; acc_mode = 1'b0; A = 3'd6; B = 3'd5; C = 3'd1;
    nd = 0; last = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        check("hold.P", 32'(P), 31);
        if (last >= 0) check("hold.gap", i - last, 2*N+1);
        last = i;
        nd++;
      end
    end
    check("hold.done_count", nd, 5);
    start = 1'b0;
    wait_idle("hold");
    mdl_p = 31; mdl_o = 1'b0;

    // Asynchronous reset mid-operation
    run_op(7, 7, 7, 1, "prerst");
    @(negedge clk);
    start = 1'b1; acc_mode = 1'b1; A = 3'd3; B = 3'd3; C = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst.P", 32'(P), 0);
    check("mrst.busy", 32'(busy), 0);
    check("mrst.done", 32'(done), 0);
    check("mrst.ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_p = 0; mdl_o = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("mrst.no_done", nd, 0);
    run_op(1, 3, 6, 0, "mrst.op"); check("mrst.const", 32'(P), 39);

    // Randomized mix of fresh and accumulating operations
    for (int i = 0; i < 150; i++) begin
      a = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 7));
      m = ($urandom_range(0, 3) != 0);
      run_op(a, b, c, m, "rnd");
    end

    // Wider instance
    run8(255, 255, 255, "w8max");
    check("w8max.const", 32'(p8), 130050);
    for (int i = 0; i < 8; i++)
      run8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), "w8rnd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nhancong_nbit_seq.md
# nhancong_nbit_seq

Sequential, parametrised multiply-add unit that computes P = A*B + C*C for N-bit unsigned operands using one shared shift-add datapath. It is the multi-cycle successor of the 3-bit combinational multiply-add: it trades latency for area, adds a start/done handshake, and adds an optional accumulate mode with saturation. It sits behind a simple controller that issues one operation at a time.

## Interface
- N, default 3: operand width in bits, N >= 2.
- AW, default 2*N+4: width of result/accumulator P, AW >= 2*N+1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only while busy=0.
- acc_mode  input  1  sampled with start: 0 = P := A*B+C*C, 1 = P := P + A*B + C*C.
- A  input  N  unsigned operand, sampled with start.
- B  input  N  unsigned operand, sampled with start.
- C  input  N  unsigned operand, squared, sampled with start.
- P  output  AW  result register; holds its value until the next completion.
- done  output  1  one-cycle pulse: P and ovf are valid and updated.
- busy  output  1  operation in progress; start is ignored while high.
- ovf  output  1  saturation flag (sticky in accumulate mode).

## Operation
- States: IDLE, MUL_AB, MUL_CC. Internal registers: latched opA, opB, opC, bit counter cnt (clog2 N bits), accumulator acc (AW bits), op_ovf.
- IDLE, start=1: latch A, B, C; acc := (acc_mode ? P : 0); op_ovf := (acc_mode ? ovf : 0); cnt := 0; go to MUL_AB; busy := 1.
- MUL_AB, each cycle: if opB[cnt] = 1, acc := acc + (opA << cnt). On cnt = N-1: cnt := 0 and go to MUL_CC. Otherwise cnt := cnt+1.
- MUL_CC, each cycle: if opC[cnt] = 1, acc := acc + (opC << cnt). On cnt = N-1: P := final acc, ovf := final op_ovf, done := 1, busy := 0, go to IDLE.
- Arithmetic: every add is done at AW+1 bits. If the sum is >= 2^AW, acc := 2^AW-1 (all ones) and op_ovf := 1. Once saturated, acc stays at all ones for the rest of the operation.
- With acc_mode=0 overflow is impossible, since the max 2*(2^N-1)^2 < 2^(2N+1); ovf then reads 0.
- ovf is cleared only by reset or by completing an operation started with acc_mode=0.
- P and ovf change only on the completion edge and on reset. During an operation P keeps its previous value.
- start while busy=1 is ignored with no effect, and start is not queued. Operand changes while busy have no effect.
- Reset (any time, including mid-operation): state := IDLE, P := 0, ovf := 0, done := 0, busy := 0, acc := 0, cnt := 0. A partially computed result is discarded.

## Timing
- start is accepted at edge t. The datapath cycles run on edges t+1 .. t+2N.
- busy is high after edge t and low after edge t+2N.
- done is high for exactly the cycle after edge t+2N. P and ovf are updated at that same edge t+2N.
- Latency from the accepting edge to done is 2N cycles (6 for N=3).
- Back-to-back operation: start held high during the done cycle is accepted at the next edge. This gives a throughput of one operation per 2N+1 cycles.
- Reset values: P=0, done=0, busy=0, ovf=0.

## Test plan
- N=3, AW=10, acc_mode=0. Apply A=7,B=2,C=4 with a 1-cycle start -> busy is high for 6 cycles, then done pulses once with P=30, ovf=0. Follow with A=4,B=6,C=2 -> P=28. Follow with A=0,B=7,C=3 -> P=9. Follow with A=4,B=2,C=0 -> P=8.
- Accumulate: A=7,B=2,C=4, acc_mode=0 -> P=30. Then A=4,B=6,C=2, acc_mode=1 -> P=58. Then A=6,B=5,C=1, acc_mode=1 -> P=89.
- Saturation: after an acc_mode=0 op with A=B=C=7 (P=98), issue 10 more ops with A=B=C=7, acc_mode=1.
  - After the 9th accumulating op: P=980, ovf=0.
  - After the 10th: P=1023, ovf=1.
  - A further acc_mode=1 op leaves P=1023, ovf=1.
  - An acc_mode=0 op with A=1,B=1,C=0 -> P=1, ovf=0.
- Busy/handshake: pulse start again 2 cycles after acceptance with different operands -> the pulse is ignored, and the first result and a single done pulse are unchanged. Hold start high continuously with A=6,B=5,C=1 -> done pulses every 7 cycles, each with P=31.
- Reset mid-operation: assert rst_n=0 asynchronously 3 cycles into an operation (between edges) -> P=0, busy=0, done=0, ovf=0 immediately. After release, no done appears until a new start. A new op A=1,B=3,C=6 -> P=39.
- Width generality: N=8, AW=20. A=255,B=255,C=255 -> done after 16 cycles, P=130050, ovf=0.
